stream_demultiplexor: RTL and testbench

STREAM_DEMULTIPLEXOR -- requirements
Module: stream_demultiplexor

---
 rtl/stream_demultiplexor.sv | 115 +++++++++++
 tb/tb_stream_demultiplexor.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/stream_demultiplexor.sv
// Routes one input word per cycle into one of four per-port FIFOs; a word shows on its port one cycle after it is accepted.
// The source stalls only when the FIFO picked by Sel is full. Each port drains on its own Valid/Ready handshake.

module stream_demultiplexor_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_dat,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dat,
  output logic             o_vld,
  output logic             o_full
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  // A full FIFO refuses the push even if the same edge pops: no pass-through.
  assign w_push = i_push & ~o_full;
  assign w_pop  = i_pop & o_vld;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_dat;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_dat  = r_mem[r_rd_ptr];
  assign o_vld  = (r_count != '0);
  assign o_full = (r_count == FULL_CNT);
endmodule

module stream_demultiplexor #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [WIDTH-1:0] In,
  input  logic [1:0]       Sel,
  input  logic             InValid,
  output logic             InReady,
  output logic [WIDTH-1:0] Out1,
  output logic [WIDTH-1:0] Out2,
  output logic [WIDTH-1:0] Out3,
  output logic [WIDTH-1:0] Out4,
  output logic             Valid1,
  output logic             Valid2,
  output logic             Valid3,
  output logic             Valid4,
  input  logic             Ready1,
  input  logic             Ready2,
  input  logic             Ready3,
  input  logic             Ready4,
  output logic             Busy
);
  logic [3:0]       w_rdy;
  logic [3:0]       w_vld;
  logic [3:0]       w_full;
  logic [WIDTH-1:0] w_head [4];

  assign w_rdy = {Ready4, Ready3, Ready2, Ready1};

  for (genvar g = 0; g < 4; g++) begin : g_port
    stream_demultiplexor_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
    ) u_fifo (
      .i_clk  (Clk),
      .i_rst  (Reset),
      .i_push (InValid && (Sel == 2'(g))),
      .i_dat  (In),
      .i_pop  (w_rdy[g]),
      .o_dat  (w_head[g]),
      .o_vld  (w_vld[g]),
      .o_full (w_full[g])
    );
  end

  // Ready depends only on the selected FIFO's fill level, never on InValid or ReadyN.
  assign InReady = ~w_full[Sel];

  assign Out1   = w_head[0];
  assign Out2   = w_head[1];
  assign Out3   = w_head[2];
  assign Out4   = w_head[3];
  assign Valid1 = w_vld[0];
  assign Valid2 = w_vld[1];
  assign Valid3 = w_vld[2];
  assign Valid4 = w_vld[3];
  assign Busy   = |w_vld;
endmodule

// File: tb/tb_stream_demultiplexor.sv
// Bench for stream_demultiplexor: directed vector table, reset-mid-transfer sequence, randomized queue-model traffic.
module tb_stream_demultiplexor;
  localparam int WIDTH = 32;
  localparam int DEPTH = 2;

  logic             Clk = 1'b0;
  logic             Reset;
  logic [WIDTH-1:0] In;
  logic [1:0]       Sel;
  logic             InValid;
  logic             InReady;
  logic [WIDTH-1:0] Out1, Out2, Out3, Out4;
  logic             Valid1, Valid2, Valid3, Valid4;
  logic             Ready1, Ready2, Ready3, Ready4;
  logic             Busy;

  int n_chk = 0;
  int n_fail = 0;

  stream_demultiplexor #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .Clk(Clk), .Reset(Reset), .In(In), .Sel(Sel), .InValid(InValid), .InReady(InReady),
    .Out1(Out1), .Out2(Out2), .Out3(Out3), .Out4(Out4),
    .Valid1(Valid1), .Valid2(Valid2), .Valid3(Valid3), .Valid4(Valid4),
    .Ready1(Ready1), .Ready2(Ready2), .Ready3(Ready3), .Ready4(Ready4),
    .Busy(Busy)
  );

  always #5 Clk = ~Clk;

  logic [3:0] w_vld;
  assign w_vld = {Valid4, Valid3, Valid2, Valid1};

  function automatic logic [WIDTH-1:0] out_of(int p);
    case (p)
      0: return Out1;
      1: return Out2;
      2: return Out3;
      default: return Out4;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_rdy(input logic [3:0] r);
    {Ready4, Ready3, Ready2, Ready1} = r;
  endtask

  typedef struct {
    logic [1:0]  sel;
    logic [31:0] dat;
    logic        vld;
    logic [3:0]  rdy;
    logic        exp_inrdy;
    logic [3:0]  exp_valid;
    logic        exp_busy;
    int          out_port;
    logic [31:0] exp_out;
  } vec_t;

  vec_t vt [12];

  logic [31:0] mq [4][$];

  initial begin
    // sel, dat, vld, rdy, InReady(pre-edge), Valid4..1, Busy, port to check (-1 none), its Out
    vt[0]  = '{2'd2, 32'hDEADBEEF, 1'b1, 4'b0000, 1'b1, 4'b0100, 1'b1, 2, 32'hDEADBEEF};
    vt[1]  = '{2'd0, 32'h1,        1'b1, 4'b0000, 1'b1, 4'b0101, 1'b1, 0, 32'h1};
    vt[2]  = '{2'd0, 32'h2,        1'b1, 4'b0000, 1'b1, 4'b0101, 1'b1, 0, 32'h1};
    vt[3]  = '{2'd0, 32'h3,        1'b1, 4'b0000, 1'b0, 4'b0101, 1'b1, 0, 32'h1};
    vt[4]  = '{2'd1, 32'h3,        1'b0, 4'b0000, 1'b1, 4'b0101, 1'b1, 0, 32'h1};
    vt[5]  = '{2'd0, 32'h3,        1'b1, 4'b0001, 1'b0, 4'b0101, 1'b1, 0, 32'h2};
    vt[6]  = '{2'd0, 32'h3,        1'b1, 4'b0001, 1'b1, 4'b0101, 1'b1, 0, 32'h3};
    vt[7]  = '{2'd3, 32'h0,        1'b0, 4'b0100, 1'b1, 4'b0001, 1'b1, 0, 32'h3};
    vt[8]  = '{2'd3, 32'hAA,       1'b1, 4'b0010, 1'b1, 4'b1001, 1'b1, 3, 32'hAA};
    vt[9]  = '{2'd1, 32'hA,        1'b1, 4'b1001, 1'b1, 4'b0010, 1'b1, 1, 32'hA};
    vt[10] = '{2'd1, 32'hB,        1'b1, 4'b0010, 1'b1, 4'b0010, 1'b1, 1, 32'hB};
    vt[11] = '{2'd0, 32'h0,        1'b0, 4'b0010, 1'b1, 4'b0000, 1'b0, -1, 32'h0};

    Reset = 1'b1; In = '0; Sel = '0; InValid = 1'b0; set_rdy(4'b0000);
    #2;
    chk("rst_valid", {28'h0, w_vld}, 32'h0);
    chk("rst_busy", {31'h0, Busy}, 32'h0);
    chk("rst_inready", {31'h0, InReady}, 32'h1);
    for (int p = 0; p < 4; p++) chk($sformatf("rst_out%0d", p + 1), out_of(p), 32'h0);
    #10 Reset = 1'b0;

    for (int i = 0; i < 12; i++) begin
      Sel = vt[i].sel; In = vt[i].dat; InValid = vt[i].vld; set_rdy(vt[i].rdy);
      #1;
      chk($sformatf("vec%0d_inready", i), {31'h0, InReady}, {31'h0, vt[i].exp_inrdy});
      @(posedge Clk); #1;
      chk($sformatf("vec%0d_valid", i), {28'h0, w_vld}, {28'h0, vt[i].exp_valid});
      chk($sformatf("vec%0d_busy", i), {31'h0, Busy}, {31'h0, vt[i].exp_busy});
      if (vt[i].out_port >= 0)
        chk($sformatf("vec%0d_out", i), out_of(vt[i].out_port), vt[i].exp_out);
    end

    // Fill every port (port 1 to full), then reset between edges.
    InValid = 1'b1; set_rdy(4'b0000);
    for (int k = 0; k < 5; k++) begin
      Sel = (k == 0) ? 2'd0 : 2'(k - 1);
      In = 32'h10 + 32'(k);
      @(posedge Clk); #1;
    end
    InValid = 1'b0; Sel = 2'd0;
    #1;
    chk("fill_valid", {28'h0, w_vld}, 32'hF);
    chk("fill_inready", {31'h0, InReady}, 32'h0);
    #2 Reset = 1'b1;
    #1;
    chk("midrst_valid", {28'h0, w_vld}, 32'h0);
    chk("midrst_busy", {31'h0, Busy}, 32'h0);
    chk("midrst_inready", {31'h0, InReady}, 32'h1);
    chk("midrst_out1", Out1, 32'h0);
    #2 Reset = 1'b0;
    set_rdy(4'b1111);
    for (int k = 0; k < 3; k++) begin
      @(posedge Clk); #1;
      chk($sformatf("postrst_valid%0d", k), {28'h0, w_vld}, 32'h0);
    end
    set_rdy(4'b0000); InValid = 1'b1; Sel = 2'd1; In = 32'h77;
    @(posedge Clk); #1;
    InValid = 1'b0;
    chk("first_accept_valid", {28'h0, w_vld}, 32'h2);
    chk("first_accept_out2", Out2, 32'h77);
    set_rdy(4'b0010);
    @(posedge Clk); #1;
    chk("drain_valid", {28'h0, w_vld}, 32'h0);

    // Randomized traffic against a per-port queue model; source holds until accepted.
    begin
      logic       held;
      logic       acc;
      logic [3:0] rdy;
      held = 1'b0;
      for (int c = 0; c < 10000; c++) begin
        if (!held) begin
          InValid = ($urandom_range(0, 3) != 0);
          Sel = 2'($urandom_range(0, 3));
          In = $urandom;
        end
        rdy = 4'($urandom);
        set_rdy(rdy);
        #1;
        acc = InValid && (mq[Sel].size() < DEPTH);
        chk("rnd_inready", {31'h0, InReady}, {31'h0, (mq[Sel].size() < DEPTH)});
        chk("rnd_busy", {31'h0, Busy},
            {31'h0, (mq[0].size() + mq[1].size() + mq[2].size() + mq[3].size()) != 0});
        for (int p = 0; p < 4; p++) begin
          chk($sformatf("rnd_valid%0d", p + 1), {31'h0, w_vld[p]}, {31'h0, mq[p].size() != 0});
          if (mq[p].size() != 0)
            chk($sformatf("rnd_out%0d", p + 1), out_of(p), mq[p][0]);
        end
        @(posedge Clk);
        for (int p = 0; p < 4; p++)
          if (rdy[p] && mq[p].size() != 0) void'(mq[p].pop_front());
        if (acc) mq[Sel].push_back(In);
        held = InValid && !acc;
        #1;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
